exu_seq: RTL and testbench

Multi-cycle execute sequencer that owns the single shared ALU in the EXU. Accepts one decoded instruction per transaction over a valid/ready handshake and time-multiplexes the ALU across two phases: primary result, then next-PC target. A memory phase for `lw`/`sw` sits between the two. Results go to writeback and the IFU through a second valid/ready handshake.

---
 rtl/exu_seq_pkg.sv | 57 +++++
 rtl/exu_seq.sv | 174 +++++++++++++++++
 tb/tb_exu_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/exu_seq_pkg.sv
// Shared constants for the EXU execute sequencer: widths, instruction ids,
// ALU function codes and sequencer state encodings.
package exu_seq_pkg;

  localparam int ISA_WIDTH       = 32;
  localparam int INST_NUM_WIDTH  = 4;
  localparam int IMM_WIDTH       = 32;
  localparam int ALU_FUNC_WIDTH  = 3;
  localparam int SEQ_STATE_WIDTH = 3;

  // Ids not listed here (0, 13..15) are treated as unknown instructions.
  localparam logic [INST_NUM_WIDTH-1:0] INST_AUIPC  = 4'd1;
  localparam logic [INST_NUM_WIDTH-1:0] INST_JAL    = 4'd2;
  localparam logic [INST_NUM_WIDTH-1:0] INST_JALR   = 4'd3;
  localparam logic [INST_NUM_WIDTH-1:0] INST_BEQ    = 4'd4;
  localparam logic [INST_NUM_WIDTH-1:0] INST_BNE    = 4'd5;
  localparam logic [INST_NUM_WIDTH-1:0] INST_LW     = 4'd6;
  localparam logic [INST_NUM_WIDTH-1:0] INST_SW     = 4'd7;
  localparam logic [INST_NUM_WIDTH-1:0] INST_ADDI   = 4'd8;
  localparam logic [INST_NUM_WIDTH-1:0] INST_SLTIU  = 4'd9;
  localparam logic [INST_NUM_WIDTH-1:0] INST_ADD    = 4'd10;
  localparam logic [INST_NUM_WIDTH-1:0] INST_SUB    = 4'd11;
  localparam logic [INST_NUM_WIDTH-1:0] INST_EBREAK = 4'd12;

  localparam logic [ALU_FUNC_WIDTH-1:0] NO_FUNC = 3'd0;
  localparam logic [ALU_FUNC_WIDTH-1:0] ADD     = 3'd1;
  localparam logic [ALU_FUNC_WIDTH-1:0] SUB     = 3'd2;
  localparam logic [ALU_FUNC_WIDTH-1:0] EQ      = 3'd3;
  localparam logic [ALU_FUNC_WIDTH-1:0] NE      = 3'd4;
  localparam logic [ALU_FUNC_WIDTH-1:0] LESS_U  = 3'd5;

  typedef enum logic [SEQ_STATE_WIDTH-1:0] {
    SEQ_IDLE = 3'd0,
    SEQ_OP   = 3'd1,
    SEQ_MEM  = 3'd2,
    SEQ_TGT  = 3'd3,
    SEQ_DONE = 3'd4
  } seq_state_e;

  function automatic logic is_mem(input logic [INST_NUM_WIDTH-1:0] inst);
    return (inst == INST_LW) || (inst == INST_SW);
  endfunction

  function automatic logic is_ctrl(input logic [INST_NUM_WIDTH-1:0] inst);
    return (inst == INST_JAL) || (inst == INST_JALR) ||
           (inst == INST_BEQ) || (inst == INST_BNE);
  endfunction

  function automatic logic writes_rd(input logic [INST_NUM_WIDTH-1:0] inst);
    case (inst)
      INST_AUIPC, INST_JAL, INST_JALR, INST_LW,
      INST_ADDI, INST_SLTIU, INST_ADD, INST_SUB: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exu_seq.sv
// Multi-cycle execute sequencer sharing one ALU across OP and TGT phases,
// with a MEM phase for lw/sw. Optional EXU_SEQ_FAST_PC_EN lets non-control
// instructions skip TGT using a private pc+4 incrementer.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never waits on ready, and the producer holds its
// payload stable while valid is high and ready is low.
module exu_seq
  import exu_seq_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INST_NUM_WIDTH-1:0] inst_num,
  input  logic [IMM_WIDTH-1:0]      imm,
  input  logic [ISA_WIDTH-1:0]      pc,
  input  logic [ISA_WIDTH-1:0]      src1,
  input  logic [ISA_WIDTH-1:0]      src2,
  output logic [ISA_WIDTH-1:0]      alu_a,
  output logic [ISA_WIDTH-1:0]      alu_b,
  output logic [ALU_FUNC_WIDTH-1:0] alu_func,
  input  logic [ISA_WIDTH-1:0]      alu_result,
  output logic                      mem_req,
  output logic                      mem_wen,
  output logic [ISA_WIDTH-1:0]      mem_addr,
  output logic [ISA_WIDTH-1:0]      mem_wdata,
  input  logic                      mem_ack,
  input  logic [ISA_WIDTH-1:0]      mem_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      wb_en,
  output logic [ISA_WIDTH-1:0]      wb_data,
  output logic [ISA_WIDTH-1:0]      next_pc,
  output logic                      ebreak,
  output logic [SEQ_STATE_WIDTH-1:0] dbg_state
);

`ifdef EXU_SEQ_FAST_PC_EN
  localparam bit FAST_PC = 1'b1;
`else
  localparam bit FAST_PC = 1'b0;
`endif

  localparam logic [ISA_WIDTH-1:0] FOUR = 32'd4;

  seq_state_e                state_q, state_d;
  logic [INST_NUM_WIDTH-1:0] inst_q, inst_d;
  logic [IMM_WIDTH-1:0]      imm_q, imm_d;
  logic [ISA_WIDTH-1:0]      pc_q, pc_d;
  logic [ISA_WIDTH-1:0]      src1_q, src1_d;
  logic [ISA_WIDTH-1:0]      src2_q, src2_d;
  logic [ISA_WIDTH-1:0]      res_q, res_d;
  logic [ISA_WIDTH-1:0]      next_pc_q, next_pc_d;
  logic                      skip_tgt;

  assign dbg_state = state_q;
  // Only control-flow instructions need the ALU for their target when fast PC is on.
  assign skip_tgt  = FAST_PC && !is_ctrl(inst_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEQ_IDLE;
      inst_q    <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      res_q     <= '0;
      next_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      res_q     <= res_d;
      next_pc_q <= next_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    res_d     = res_q;
    next_pc_d = next_pc_q;
    in_ready  = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_func  = NO_FUNC;
    mem_req   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    out_valid = 1'b0;
    wb_en     = 1'b0;
    wb_data   = '0;
    next_pc   = '0;
    ebreak    = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          inst_d  = inst_num;
          imm_d   = imm;
          pc_d    = pc;
          src1_d  = src1;
          src2_d  = src2;
          state_d = SEQ_OP;
        end
      end

      SEQ_OP: begin
        case (inst_q)
          INST_AUIPC:                    begin alu_a = pc_q;   alu_b = imm_q;  alu_func = ADD;    end
          INST_JAL, INST_JALR:           begin alu_a = pc_q;   alu_b = FOUR;   alu_func = ADD;    end
          INST_BEQ:                      begin alu_a = src1_q; alu_b = src2_q; alu_func = EQ;     end
          INST_BNE:                      begin alu_a = src1_q; alu_b = src2_q; alu_func = NE;     end
          INST_LW, INST_SW, INST_ADDI:   begin alu_a = src1_q; alu_b = imm_q;  alu_func = ADD;    end
          INST_SLTIU:                    begin alu_a = src1_q; alu_b = imm_q;  alu_func = LESS_U; end
          INST_ADD:                      begin alu_a = src1_q; alu_b = src2_q; alu_func = ADD;    end
          INST_SUB:                      begin alu_a = src1_q; alu_b = src2_q; alu_func = SUB;    end
          default:                       begin alu_a = '0;     alu_b = '0;     alu_func = NO_FUNC; end
        endcase
        res_d = alu_result;
        if (FAST_PC) next_pc_d = pc_q + FOUR;
        if (is_mem(inst_q))  state_d = SEQ_MEM;
        else if (skip_tgt)   state_d = SEQ_DONE;
        else                 state_d = SEQ_TGT;
      end

      SEQ_MEM: begin
        mem_req   = 1'b1;
        mem_addr  = res_q;
        mem_wen   = (inst_q == INST_SW);
        mem_wdata = src2_q;
        if (mem_ack) begin
          if (inst_q == INST_LW) res_d = mem_rdata;
          state_d = skip_tgt ? SEQ_DONE : SEQ_TGT;
        end
      end

      SEQ_TGT: begin
        alu_func = ADD;
        case (inst_q)
          INST_JAL:           begin alu_a = pc_q;   alu_b = imm_q; end
          INST_JALR:          begin alu_a = src1_q; alu_b = imm_q; end
          INST_BEQ, INST_BNE: begin alu_a = pc_q;   alu_b = res_q[0] ? imm_q : FOUR; end
          default:            begin alu_a = pc_q;   alu_b = FOUR;  end
        endcase
        next_pc_d = (inst_q == INST_JALR) ? {alu_result[ISA_WIDTH-1:1], 1'b0} : alu_result;
        state_d   = SEQ_DONE;
      end

      SEQ_DONE: begin
        out_valid = 1'b1;
        wb_en     = writes_rd(inst_q);
        wb_data   = res_q;
        next_pc   = next_pc_q;
        ebreak    = (inst_q == INST_EBREAK);
        if (out_ready) state_d = SEQ_IDLE;
      end

      default: state_d = SEQ_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exu_seq.sv
// Directed bench for exu_seq: ALU and memory responders, a result scoreboard
// and latency/handshake checks including reset in the middle of a load.
module tb_exu_seq;
  import exu_seq_pkg::*;

  localparam int W = 2 + 2 * ISA_WIDTH;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [INST_NUM_WIDTH-1:0]  inst_num = '0;
  logic [IMM_WIDTH-1:0]       imm = '0;
  logic [ISA_WIDTH-1:0]       pc = '0, src1 = '0, src2 = '0;
  logic [ISA_WIDTH-1:0]       alu_a, alu_b, alu_result;
  logic [ALU_FUNC_WIDTH-1:0]  alu_func;
  logic                       mem_req, mem_wen;
  logic [ISA_WIDTH-1:0]       mem_addr, mem_wdata;
  logic                       mem_ack = 1'b0;
  logic [ISA_WIDTH-1:0]       mem_rdata = '0;
  logic                       out_valid;
  logic                       out_ready = 1'b1;
  logic                       wb_en, ebreak;
  logic [ISA_WIDTH-1:0]       wb_data, next_pc;
  logic [SEQ_STATE_WIDTH-1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  exu_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_num(inst_num), .imm(imm), .pc(pc), .src1(src1), .src2(src2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_result(alu_result),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .wb_data(wb_data), .next_pc(next_pc), .ebreak(ebreak),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Reference shared ALU
  always_comb begin
    case (alu_func)
      ADD:     alu_result = alu_a + alu_b;
      SUB:     alu_result = alu_a - alu_b;
      EQ:      alu_result = {31'd0, alu_a == alu_b};
      NE:      alu_result = {31'd0, alu_a != alu_b};
      LESS_U:  alu_result = {31'd0, alu_a < alu_b};
      default: alu_result = '0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] inst, input logic [31:0] p,
                                         input logic [31:0] im, input logic [31:0] s1,
                                         input logic [31:0] s2, input logic [31:0] rd);
    logic [31:0] res, npc, sum;
    logic        we, eb;
    res = '0; npc = p + 32'd4; we = 1'b0; eb = 1'b0;
    case (inst)
      INST_AUIPC:  begin res = p + im; we = 1'b1; end
      INST_JAL:    begin res = p + 32'd4; npc = p + im; we = 1'b1; end
      INST_JALR:   begin res = p + 32'd4; sum = s1 + im; npc = {sum[31:1], 1'b0}; we = 1'b1; end
      INST_BEQ:    begin res = {31'd0, s1 == s2}; if (s1 == s2) npc = p + im; end
      INST_BNE:    begin res = {31'd0, s1 != s2}; if (s1 != s2) npc = p + im; end
      INST_LW:     begin res = rd; we = 1'b1; end
      INST_SW:     res = s1 + im;
      INST_ADDI:   begin res = s1 + im; we = 1'b1; end
      INST_SLTIU:  begin res = {31'd0, s1 < im}; we = 1'b1; end
      INST_ADD:    begin res = s1 + s2; we = 1'b1; end
      INST_SUB:    begin res = s1 - s2; we = 1'b1; end
      INST_EBREAK: eb = 1'b1;
      default:     res = '0;
    endcase
    return {we, eb, res, npc};
  endfunction

  function automatic int exp_latency(input logic [3:0] inst, input int mem_n);
    int lat;
    lat = 3 + mem_n;
`ifdef EXU_SEQ_FAST_PC_EN
    if (!(inst == INST_JAL || inst == INST_JALR || inst == INST_BEQ || inst == INST_BNE))
      lat = lat - 1;
`endif
    return lat;
  endfunction

  // Driver: issue one instruction, service MEM, then drain DONE after hold cycles.
  task automatic run_inst(input string tag, input logic [3:0] inst, input logic [31:0] p,
                          input logic [31:0] im, input logic [31:0] s1, input logic [31:0] s2,
                          input int mem_n, input logic [31:0] rd, input int hold);
    int cyc, mem_cycles;
    logic mem_ok, busy_ok;
    logic [W-1:0] got, exp;
    exp_q.push_back(model(inst, p, im, s1, s2, rd));
    check({tag, " in_ready idle"}, W'(in_ready), W'(1));
    inst_num = inst; pc = p; imm = im; src1 = s1; src2 = s2;
    out_ready = (hold == 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    inst_num = '0; pc = '0; imm = '0; src1 = '0; src2 = '0;
    cyc = 1; mem_cycles = 0; mem_ok = 1'b1; busy_ok = 1'b1;
    while (!out_valid && cyc < 64) begin
      if (in_ready) busy_ok = 1'b0;
      if (mem_req) begin
        mem_cycles++;
        if (mem_addr !== s1 + im || mem_wen !== (inst == INST_SW) || mem_wdata !== s2)
          mem_ok = 1'b0;
        mem_ack = (mem_cycles == mem_n);
        mem_rdata = rd;
      end else begin
        mem_ack = 1'b0;
      end
      step();
      cyc++;
    end
    mem_ack = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
    check({tag, " latency"}, W'(cyc), W'(exp_latency(inst, mem_n)));
    check({tag, " in_ready busy"}, W'(busy_ok && !in_ready), W'(1));
    if (mem_n > 0) check({tag, " mem phase"}, W'({mem_ok, mem_cycles[7:0]}), W'({1'b1, mem_n[7:0]}));
    got = {wb_en, ebreak, wb_data, next_pc};
    exp = exp_q.pop_front();
    check({tag, " result"}, got, exp);
    for (int h = 0; h < hold; h++) begin
      step();
      check({tag, " hold"}, {wb_en, ebreak, wb_data, next_pc}, exp);
      check({tag, " hold handshake"}, W'({out_valid, in_ready}), W'(2'b10));
    end
    out_ready = 1'b1;
    step();
    check({tag, " back to idle"}, W'({out_valid, in_ready}), W'(2'b01));
  endtask

  initial begin
    logic seen_valid;
    logic [31:0] a, b;
    repeat (3) step();
    rst = 1'b0;
    check("reset handshake", W'({in_ready, out_valid}), W'(2'b10));
    check("reset mem", W'({mem_req, mem_wen, mem_addr, mem_wdata}), W'(0));
    check("reset wb", W'({wb_en, ebreak, wb_data, next_pc}), W'(0));
    check("reset alu", W'({alu_a, alu_b, alu_func}), W'({64'd0, NO_FUNC}));
    check("reset state", W'(dbg_state), W'(SEQ_IDLE));

    run_inst("addi",     INST_ADDI,   32'h8000_0000, 32'hFFFF_FFFD, 32'd5, 32'd0, 0, 0, 0);
    run_inst("beq taken", INST_BEQ,   32'h8000_0010, 32'h20, 32'd7, 32'd7, 0, 0, 0);
    run_inst("beq not",  INST_BEQ,    32'h8000_0010, 32'h20, 32'd7, 32'd8, 0, 0, 0);
    run_inst("jalr",     INST_JALR,   32'h100, 32'd0, 32'h2003, 32'd0, 0, 0, 0);
    run_inst("lw",       INST_LW,     32'h200, 32'd8, 32'h1000, 32'd0, 3, 32'hDEAD_BEEF, 0);
    run_inst("sw hold",  INST_SW,     32'h204, 32'd4, 32'h3000, 32'hCAFE_F00D, 1, 0, 4);
    run_inst("after sw", INST_ADD,    32'h208, 32'd0, 32'd10, 32'd20, 0, 0, 0);
    run_inst("jal",      INST_JAL,    32'h400, 32'hFFFF_FF00, 32'd0, 32'd0, 0, 0, 0);
    run_inst("bne taken", INST_BNE,   32'h500, 32'h40, 32'd1, 32'd2, 0, 0, 0);
    run_inst("auipc",    INST_AUIPC,  32'hFFFF_F000, 32'h2000, 32'd0, 32'd0, 0, 0, 0);
    run_inst("sltiu",    INST_SLTIU,  32'h600, 32'hFFFF_FFFF, 32'd3, 32'd0, 0, 0, 1);
    run_inst("sub wrap", INST_SUB,    32'hFFFF_FFFC, 32'd0, 32'd1, 32'd2, 0, 0, 0);
    run_inst("ebreak",   INST_EBREAK, 32'h700, 32'd0, 32'd9, 32'd9, 0, 0, 0);
    run_inst("unknown",  4'd14,       32'h800, 32'd4, 32'd6, 32'd7, 0, 0, 0);
    run_inst("lw ack1",  INST_LW,     32'h900, 32'hFFFF_FFFC, 32'h10, 32'd0, 1, 32'h1234_5678, 0);

    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      run_inst((i % 2) ? "rand sub" : "rand add", (i % 2) ? INST_SUB : INST_ADD,
               $urandom_range(0, 32'hFFFF) << 2, 32'd0, a, b, 0, 0, $urandom_range(0, 2));
    end

    // Reset while a load waits in MEM; the load must vanish.
    inst_num = INST_LW; pc = 32'hA00; imm = 32'd0; src1 = 32'h40; src2 = 32'd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8 && !mem_req; i++) step();
    check("rst mem entry", W'(mem_req), W'(1));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst in mem", W'({mem_req, in_ready, out_valid}), W'(3'b010));
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ack = (i < 2);
      if (out_valid || mem_req) seen_valid = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    check("rst dropped", W'(seen_valid), W'(0));
    run_inst("post rst", INST_ADDI, 32'hB00, 32'd1, 32'd41, 32'd0, 0, 0, 0);

    check("scoreboard empty", W'(exp_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
